// File: rtl/wisc_pkg.sv
// Shared WISC definitions: register specifier width, the hardwired zero
// register and the interlock FSM state encoding.
package wisc_pkg;
  localparam int REG_W = 4;

  typedef logic [REG_W-1:0] reg_id_t;

  localparam reg_id_t ZERO_REG = '0;

  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_STALL  = 2'b01;
  localparam logic [1:0] ST_HALTED = 2'b10;
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-control bundle between the datapath and the stall controller.
// The controller is the slave: it consumes the EX/ID fields and drives the
// pipeline enables.
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 3
);
  logic             ex_memRead;
  logic             ex_regWrite;
  logic [REG_W-1:0] ex_dstReg;
  logic [REG_W-1:0] id_srcReg1;
  logic [REG_W-1:0] id_srcReg2;
  logic             id_use1;
  logic             id_use2;
  logic             id_halt;
  logic             ex_branch_taken;
  logic             pc_wen;
  logic             if_id_wen;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ex_memRead, ex_regWrite, ex_dstReg, id_srcReg1, id_srcReg2,
           id_use1, id_use2, id_halt, ex_branch_taken,
    input  pc_wen, if_id_wen, if_id_flush, id_ex_bubble, halted, stall_cnt
  );

  modport slave (
    input  ex_memRead, ex_regWrite, ex_dstReg, id_srcReg1, id_srcReg2,
           id_use1, id_use2, id_halt, ex_branch_taken,
    output pc_wen, if_id_wen, if_id_flush, id_ex_bubble, halted, stall_cnt
  );
endinterface

// File: rtl/dff.sv
// Generic flop primitive with asynchronous active-high reset to RST_VAL.
module dff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Capture d every rising edge; rst forces RST_VAL immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end
endmodule

// File: rtl/hazard_cmp.sv
// Load-use hazard detect: the load in EX writes a register the ID
// instruction actually reads. Register 0 is hardwired zero and never hazards.
module hazard_cmp
  import wisc_pkg::*;
#(
  parameter int REG_W = wisc_pkg::REG_W
) (
  input  logic             ex_memRead,
  input  logic             ex_regWrite,
  input  logic [REG_W-1:0] ex_dstReg,
  input  logic [REG_W-1:0] id_srcReg1,
  input  logic [REG_W-1:0] id_srcReg2,
  input  logic             id_use1,
  input  logic             id_use2,
  output logic             hazard
);
  logic match1;
  logic match2;

  assign match1 = id_use1 && (id_srcReg1 == ex_dstReg);
  assign match2 = id_use2 && (id_srcReg2 == ex_dstReg);
  assign hazard = ex_memRead && ex_regWrite
               && (ex_dstReg != REG_W'(ZERO_REG)) && (match1 || match2);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID/EX interlock: load-use stall, branch flush and HLT freeze for the
// 16-bit WISC 5-stage pipeline. Outputs respond in the same cycle.
module hazard_stall_ctrl
  import wisc_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int REG_W      = wisc_pkg::REG_W,
  parameter int CNT_W      = 3
) (
  input  logic                clk,
  input  logic                rst,
  hazard_stall_ctrl_if.slave  bus
);
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;
  logic             pc_wen, if_id_wen, if_id_flush, id_ex_bubble;

  hazard_cmp #(.REG_W(REG_W)) u_hazard_cmp (
    .ex_memRead  (bus.ex_memRead),
    .ex_regWrite (bus.ex_regWrite),
    .ex_dstReg   (bus.ex_dstReg),
    .id_srcReg1  (bus.id_srcReg1),
    .id_srcReg2  (bus.id_srcReg2),
    .id_use1     (bus.id_use1),
    .id_use2     (bus.id_use2),
    .hazard      (hazard)
  );

  dff #(.W(2), .RST_VAL(ST_RUN)) u_state_ff (
    .clk (clk), .rst (rst), .d (state_d), .q (state_q)
  );

  dff #(.W(CNT_W), .RST_VAL('0)) u_cnt_ff (
    .clk (clk), .rst (rst), .d (cnt_d), .q (cnt_q)
  );

  // Next state and enables; branch beats hazard/stall, which beats halt.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_wen       = 1'b1;
    if_id_wen    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.ex_branch_taken) begin
          // Load the target, squash the wrong-path instruction in ID.
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = ST_RUN;
          cnt_d        = '0;
        end else if (hazard) begin
          pc_wen       = 1'b0;
          if_id_wen    = 1'b0;
          id_ex_bubble = 1'b1;
          if (LOAD_STALL == 1) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            state_d = ST_STALL;
            cnt_d   = CNT_W'(LOAD_STALL - 1);
          end
        end else if (bus.id_halt) begin
          // HLT itself flows into EX; fetch freezes behind it.
          pc_wen    = 1'b0;
          if_id_wen = 1'b0;
          state_d   = ST_HALTED;
        end
      end
      ST_STALL: begin
        if (bus.ex_branch_taken) begin
          // EX should hold a bubble here, but a taken branch still wins.
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = ST_RUN;
          cnt_d        = '0;
        end else begin
          pc_wen       = 1'b0;
          if_id_wen    = 1'b0;
          id_ex_bubble = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_HALTED: begin
        pc_wen       = 1'b0;
        if_id_wen    = 1'b0;
        id_ex_bubble = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
    // Hold the front end and keep ID/EX empty while reset is asserted.
    if (rst) begin
      pc_wen       = 1'b0;
      if_id_wen    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  assign bus.pc_wen       = pc_wen;
  assign bus.if_id_wen    = if_id_wen;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.halted       = (state_q == ST_HALTED);
  assign bus.stall_cnt    = cnt_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: one instance with LOAD_STALL=1 and
// one with LOAD_STALL=3, both fed the same stimulus.
module tb_hazard_stall_ctrl;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  hazard_stall_ctrl_if #(.REG_W(4), .CNT_W(3)) b1 ();
  hazard_stall_ctrl_if #(.REG_W(4), .CNT_W(3)) b3 ();

  hazard_stall_ctrl #(.LOAD_STALL(1), .REG_W(4), .CNT_W(3)) dut1 (
    .clk (clk), .rst (rst), .bus (b1.slave)
  );
  hazard_stall_ctrl #(.LOAD_STALL(3), .REG_W(4), .CNT_W(3)) dut3 (
    .clk (clk), .rst (rst), .bus (b3.slave)
  );

  // {pc_wen, if_id_wen, if_id_flush, id_ex_bubble, halted}
  logic [4:0] o1, o3;
  assign o1 = {b1.pc_wen, b1.if_id_wen, b1.if_id_flush, b1.id_ex_bubble, b1.halted};
  assign o3 = {b3.pc_wen, b3.if_id_wen, b3.if_id_flush, b3.id_ex_bubble, b3.halted};

  // {pc_wen, if_id_flush, id_ex_bubble, halted}
  logic [3:0] f1, f3;
  assign f1 = {b1.pc_wen, b1.if_id_flush, b1.id_ex_bubble, b1.halted};
  assign f3 = {b3.pc_wen, b3.if_id_flush, b3.id_ex_bubble, b3.halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic mr, input logic rw, input logic [3:0] dst,
                       input logic [3:0] s1, input logic [3:0] s2,
                       input logic u1, input logic u2, input logic h,
                       input logic br);
    b1.ex_memRead = mr;  b3.ex_memRead = mr;
    b1.ex_regWrite = rw; b3.ex_regWrite = rw;
    b1.ex_dstReg = dst;  b3.ex_dstReg = dst;
    b1.id_srcReg1 = s1;  b3.id_srcReg1 = s1;
    b1.id_srcReg2 = s2;  b3.id_srcReg2 = s2;
    b1.id_use1 = u1;     b3.id_use1 = u1;
    b1.id_use2 = u2;     b3.id_use2 = u2;
    b1.id_halt = h;      b3.id_halt = h;
    b1.ex_branch_taken = br; b3.ex_branch_taken = br;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    next_cycle();
    #1;
    n_vec++;
    if (o1 !== 5'b00010) begin n_err++; $display("FAIL reset_out_ls1: got %b expected %b", o1, 5'b00010); end
    n_vec++;
    if (o3 !== 5'b00010) begin n_err++; $display("FAIL reset_out_ls3: got %b expected %b", o3, 5'b00010); end
    rst = 1'b0;
    #1;
    n_vec++;
    if (o1 !== 5'b11000) begin n_err++; $display("FAIL idle_out_ls1: got %b expected %b", o1, 5'b11000); end
    n_vec++;
    if (b3.stall_cnt !== 3'd0) begin n_err++; $display("FAIL idle_cnt_ls3: got %0d expected %0d", b3.stall_cnt, 0); end
  endtask

  task automatic test_load_use_1();
    do_reset();
    drive(1'b1, 1'b1, 4'h3, 4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (o1 !== 5'b00010) begin n_err++; $display("FAIL lu1_stall: got %b expected %b", o1, 5'b00010); end
    next_cycle();
    // Load moved to MEM; ID still depends on it but forwarding covers it.
    drive(1'b0, 1'b0, 4'h0, 4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (o1 !== 5'b11000) begin n_err++; $display("FAIL lu1_resume: got %b expected %b", o1, 5'b11000); end
    n_vec++;
    if (b1.stall_cnt !== 3'd0) begin n_err++; $display("FAIL lu1_cnt: got %0d expected %0d", b1.stall_cnt, 0); end
  endtask

  task automatic test_no_hazard();
    do_reset();
    drive(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (o1 !== 5'b11000) begin n_err++; $display("FAIL nh_reg0: got %b expected %b", o1, 5'b11000); end
    drive(1'b1, 1'b1, 4'h3, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (o3 !== 5'b11000) begin n_err++; $display("FAIL nh_unused_src1: got %b expected %b", o3, 5'b11000); end
    drive(1'b1, 1'b1, 4'h5, 4'h0, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (o1 !== 5'b11000) begin n_err++; $display("FAIL nh_unused_src2: got %b expected %b", o1, 5'b11000); end
    drive(1'b1, 1'b0, 4'h5, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (o1 !== 5'b11000) begin n_err++; $display("FAIL nh_no_regwrite: got %b expected %b", o1, 5'b11000); end
    drive(1'b0, 1'b1, 4'h5, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (o3 !== 5'b11000) begin n_err++; $display("FAIL nh_not_load: got %b expected %b", o3, 5'b11000); end
  endtask

  task automatic test_load_use_3();
    logic [2:0] exp_cnt [4];
    logic [4:0] exp_out [4];
    exp_cnt[0] = 3'd0; exp_cnt[1] = 3'd2; exp_cnt[2] = 3'd1; exp_cnt[3] = 3'd0;
    exp_out[0] = 5'b00010; exp_out[1] = 5'b00010; exp_out[2] = 5'b00010; exp_out[3] = 5'b11000;
    do_reset();
    drive(1'b1, 1'b1, 4'hA, 4'h0, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        next_cycle();
        drive(1'b0, 1'b0, 4'h0, 4'h0, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      #1;
      n_vec++;
      if (o3 !== exp_out[i]) begin n_err++; $display("FAIL lu3_out[%0d]: got %b expected %b", i, o3, exp_out[i]); end
      n_vec++;
      if (b3.stall_cnt !== exp_cnt[i]) begin n_err++; $display("FAIL lu3_cnt[%0d]: got %0d expected %0d", i, b3.stall_cnt, exp_cnt[i]); end
    end
  endtask

  task automatic test_branch_priority();
    do_reset();
    drive(1'b1, 1'b1, 4'h3, 4'h3, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    n_vec++;
    if (f1 !== 4'b1110) begin n_err++; $display("FAIL br_hz_ls1: got %b expected %b", f1, 4'b1110); end
    n_vec++;
    if (f3 !== 4'b1110) begin n_err++; $display("FAIL br_hz_ls3: got %b expected %b", f3, 4'b1110); end
    next_cycle();
    idle();
    #1;
    n_vec++;
    if (o1 !== 5'b11000) begin n_err++; $display("FAIL br_after_ls1: got %b expected %b", o1, 5'b11000); end
    n_vec++;
    if (o3 !== 5'b11000) begin n_err++; $display("FAIL br_after_ls3: got %b expected %b", o3, 5'b11000); end
    n_vec++;
    if (b3.stall_cnt !== 3'd0) begin n_err++; $display("FAIL br_after_cnt: got %0d expected %0d", b3.stall_cnt, 0); end
    // Taken branch while already stalling aborts the stall.
    drive(1'b1, 1'b1, 4'h6, 4'h6, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    n_vec++;
    if (f3 !== 4'b1110) begin n_err++; $display("FAIL br_in_stall: got %b expected %b", f3, 4'b1110); end
    next_cycle();
    idle();
    #1;
    n_vec++;
    if (o3 !== 5'b11000) begin n_err++; $display("FAIL br_stall_exit: got %b expected %b", o3, 5'b11000); end
  endtask

  task automatic test_halt();
    do_reset();
    drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    n_vec++;
    if (o1 !== 5'b00000) begin n_err++; $display("FAIL halt_first: got %b expected %b", o1, 5'b00000); end
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drive(1'b1, 1'b1, 4'h2, 4'h2, 4'h2, 1'b1, 1'b1, 1'b0, i[0]);
      #1;
      n_vec++;
      if (o1 !== 5'b00011) begin n_err++; $display("FAIL halted_ls1[%0d]: got %b expected %b", i, o1, 5'b00011); end
      n_vec++;
      if (o3 !== 5'b00011) begin n_err++; $display("FAIL halted_ls3[%0d]: got %b expected %b", i, o3, 5'b00011); end
    end
    rst = 1'b1;
    idle();
    #1;
    n_vec++;
    if (o1 !== 5'b00010) begin n_err++; $display("FAIL halt_rst: got %b expected %b", o1, 5'b00010); end
    next_cycle();
    rst = 1'b0;
    #1;
    n_vec++;
    if (o1 !== 5'b11000) begin n_err++; $display("FAIL halt_exit: got %b expected %b", o1, 5'b11000); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1'b1, 1'b1, 4'h7, 4'h7, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    idle();
    #1;
    n_vec++;
    if (b3.stall_cnt !== 3'd2) begin n_err++; $display("FAIL mid_stall_cnt: got %0d expected %0d", b3.stall_cnt, 2); end
    rst = 1'b1;
    #1;
    n_vec++;
    if (b3.stall_cnt !== 3'd0) begin n_err++; $display("FAIL mid_rst_cnt: got %0d expected %0d", b3.stall_cnt, 0); end
    next_cycle();
    rst = 1'b0;
    #1;
    n_vec++;
    if (o3 !== 5'b11000) begin n_err++; $display("FAIL mid_rst_exit: got %b expected %b", o3, 5'b11000); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    idle();
    test_reset();
    test_load_use_1();
    test_no_hazard();
    test_load_use_3();
    test_branch_priority();
    test_halt();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Consumer-side interlock for the ID/EX pipeline register.
- Watches the instruction latched in EX (dest reg, memRead, regWrite) against the instruction in ID (source regs).
- Generates load-use stalls, branch flushes and halt freeze.
- Drives PC write-enable, IF/ID write-enable/flush and the ID/EX bubble select for the 16-bit WISC 5-stage pipeline.

Parameters:
- LOAD_STALL, 1, bubbles inserted per load-use hazard; legal 1..7.
- REG_W, 4, register-specifier width.
- CNT_W, 3, stall counter width; must satisfy 2^CNT_W > LOAD_STALL.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_memRead  in  1  EX instruction is a load.
- ex_regWrite  in  1  EX instruction writes the register file.
- ex_dstReg  in  REG_W  EX destination register (ID/EX dstReg output).
- id_srcReg1  in  REG_W  ID source register 1.
- id_srcReg2  in  REG_W  ID source register 2.
- id_use1  in  1  ID instruction reads srcReg1.
- id_use2  in  1  ID instruction reads srcReg2.
- id_halt  in  1  ID instruction is HLT.
- ex_branch_taken  in  1  branch or jump resolved taken in EX.
- pc_wen  out  1  PC register write enable.
- if_id_wen  out  1  IF/ID register write enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_bubble  out  1  zero control fields entering ID/EX.
- halted  out  1  pipeline frozen by HLT; sticky until reset.
- stall_cnt  out  CNT_W  remaining stall cycles (debug/verification).

Behaviour:
- Reset (async, rst=1): state=RUN, cnt=0, halted=0.
  - While rst is high: pc_wen=0, if_id_wen=0, if_id_flush=0, id_ex_bubble=1.
- hazard (combinational) = ex_memRead & ex_regWrite & (ex_dstReg != 0) & ((id_use1 & id_srcReg1==ex_dstReg) | (id_use2 & id_srcReg2==ex_dstReg)).
  - Reg 0 is hardwired zero and never hazards.
- Outputs are combinational from state and inputs; state and cnt are registered. Zero-cycle response.
- Priority in every state except HALTED: ex_branch_taken > hazard/stall > id_halt.
- RUN:
  - Default: pc_wen=1, if_id_wen=1, flush=0, bubble=0.
  - ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_wen=1 (target load). Next state RUN; any hazard or halt in ID is discarded.
  - hazard: pc_wen=0, if_id_wen=0, id_ex_bubble=1.
    - LOAD_STALL=1: next state RUN.
    - Otherwise: next state STALL, cnt=LOAD_STALL-1.
  - id_halt with no hazard: pc_wen=0, if_id_wen=0, bubble=0 (HLT proceeds down the pipe). Next state HALTED.
- STALL:
  - Outputs: pc_wen=0, if_id_wen=0, id_ex_bubble=1.
  - cnt decrements each cycle; at cnt==1 the next state is RUN with cnt=0.
  - ex_branch_taken asserted here (protocol violation, since EX holds a bubble) still aborts: flush outputs as in RUN, next state RUN, cnt=0.
- HALTED:
  - Outputs: halted=1, pc_wen=0, if_id_wen=0, id_ex_bubble=1 from the second cycle on. All inputs ignored; only rst exits.
- stall_cnt mirrors cnt; it is 0 in RUN and HALTED.
- Back-to-back load-use (next ID instruction also depends on the load): no extra stall. After the bubble, the load is in MEM and MEM->EX forwarding owns it.
- Reset mid-stall: immediately RUN after deassertion; no residual bubble.

Decomposition:
- Shared package wisc_pkg: REG_W, the zero-register constant, and the state encoding RUN=2'b00, STALL=2'b01, HALTED=2'b10.
- One natural sub-module: hazard_cmp, the purely combinational hazard equation, reusable by the forwarding unit.
- State and cnt flops use the existing dff primitives with rst wired directly.

Test Plan:
- Reset, then idle inputs -> pc_wen=1, if_id_wen=1, bubble=0, stall_cnt=0, halted=0.
- LOAD_STALL=1; ex: memRead=1, regWrite=1, dst=4'h3; id: use1=1, src1=4'h3 -> one cycle with pc_wen=0, if_id_wen=0, bubble=1; next cycle (ex inputs now bubble) -> pc_wen=1.
- Same stimulus with dst=4'h0 -> no stall. Repeat with dst=3, use1=0, src1=3 -> no stall.
- LOAD_STALL=3, hazard on src2=4'hA -> exactly 3 stalled cycles, stall_cnt sequence 0,2,1 then 0 back in RUN.
- Hazard and ex_branch_taken in the same cycle -> if_id_flush=1, bubble=1, pc_wen=1, no subsequent stall.
- id_halt=1 -> halted=1 from the next cycle, pc_wen held 0 for 10 cycles despite branch_taken pulses; rst pulse -> RUN, halted=0.
